// File: rtl/axis_pkg.sv
// Shared definitions for the AXI4-Stream packet generator.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } pg_state_e;

    localparam int unsigned STRB_MAX_W = 128;

    function automatic logic [STRB_MAX_W-1:0] AXIS_TSTRB_ALL(
        input int unsigned width
    );
        logic [STRB_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < STRB_MAX_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_pktgen_ctrl.sv
// Packet generator sequencer: FSM plus beat, packet and gap counters.
module axis_pktgen_ctrl
    import axis_pkg::*;
#(
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [LW-1:0] cfg_pkt_len,
    input  logic [LW-1:0] cfg_pkt_cnt,
    input  logic [LW-1:0] cfg_gap,
    input  logic          m_valid,
    input  logic          m_ready,
    output logic          load,
    output logic          advance,
    output logic          valid_d,
    output logic          last_d,
    output logic          busy,
    output logic          done
);

    localparam logic [LW-1:0] ONE = 1;

    pg_state_e     state_q, state_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [LW-1:0] pkt_q, pkt_d;
    logic [LW-1:0] gcnt_q, gcnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] gap_q, gap_d;
    logic          busy_q, done_q;
    logic          hs;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        gcnt_d  = gcnt_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        load    = 1'b0;
        advance = 1'b0;
        valid_d = m_valid;
        hs      = m_valid && m_ready;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_pkt_len != '0 && cfg_pkt_cnt != '0) begin
                        len_d   = cfg_pkt_len;
                        cnt_d   = cfg_pkt_cnt;
                        gap_d   = cfg_gap;
                        beat_d  = '0;
                        pkt_d   = '0;
                        gcnt_d  = '0;
                        load    = 1'b1;
                        valid_d = 1'b1;
                        state_d = STREAM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            STREAM: begin
                if (hs) begin
                    advance = 1'b1;
                    if (beat_q == len_q - ONE) begin
                        beat_d = '0;
                        if (pkt_q == cnt_q - ONE) begin
                            valid_d = 1'b0;
                            state_d = DONE;
                        end else begin
                            pkt_d = pkt_q + ONE;
                            if (gap_q != '0) begin
                                valid_d = 1'b0;
                                gcnt_d  = '0;
                                state_d = GAP;
                            end
                        end
                    end else begin
                        beat_d = beat_q + ONE;
                    end
                end
            end
            GAP: begin
                if (gcnt_q == gap_q - ONE) begin
                    gcnt_d  = '0;
                    valid_d = 1'b1;
                    state_d = STREAM;
                end else begin
                    gcnt_d = gcnt_q + ONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // TLAST follows the beat counter, so it holds through stalls
        last_d = valid_d && (beat_d == len_d - ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            pkt_q   <= '0;
            gcnt_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            gcnt_q  <= gcnt_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/axis_pktgen_master.sv
// AXI4-Stream master packet generator with registered outputs.
// AXIS_PKTGEN_STALL_CNT_EN adds a saturating back-pressure cycle counter.
module axis_pktgen_master
    import axis_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_LEN_WIDTH          = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESET,
    input  logic                              start,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   cfg_seed,
    input  logic [C_LEN_WIDTH-1:0]            cfg_pkt_len,
    input  logic [C_LEN_WIDTH-1:0]            cfg_pkt_cnt,
    input  logic [C_LEN_WIDTH-1:0]            cfg_gap,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              busy,
    output logic                              done
`ifdef AXIS_PKTGEN_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int STRB_W = C_M_AXIS_TDATA_WIDTH / 8;
    localparam logic [STRB_MAX_W-1:0] STRB_ALL = AXIS_TSTRB_ALL(STRB_W);
    localparam logic [C_M_AXIS_TDATA_WIDTH-1:0] DONE_INC = 1;

    logic                            load, advance, valid_d, last_d;
    logic                            tvalid_q, tlast_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;

    axis_pktgen_ctrl #(
        .LW(C_LEN_WIDTH)
    ) u_ctrl (
        .clk         (M_AXIS_ACLK),
        .rst         (M_AXIS_ARESET),
        .start       (start),
        .cfg_pkt_len (cfg_pkt_len),
        .cfg_pkt_cnt (cfg_pkt_cnt),
        .cfg_gap     (cfg_gap),
        .m_valid     (tvalid_q),
        .m_ready     (M_AXIS_TREADY),
        .load        (load),
        .advance     (advance),
        .valid_d     (valid_d),
        .last_d      (last_d),
        .busy        (busy),
        .done        (done)
    );

    always_comb begin
        tdata_d = tdata_q;
        if (load) tdata_d = cfg_seed;
        else if (advance) tdata_d = tdata_q + DONE_INC;
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
        end else begin
            tvalid_q <= valid_d;
            tlast_q  <= last_d;
            tdata_q  <= tdata_d;
        end
    end

    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = STRB_ALL[STRB_W-1:0];

`ifdef AXIS_PKTGEN_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (load) stall_d = '0;
        else if (tvalid_q && !M_AXIS_TREADY && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) stall_q <= '0;
        else stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_axis_pktgen_master.sv
// Directed self-checking bench for axis_pktgen_master.
module tb_axis_pktgen_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_seed = '0;
    logic [15:0] cfg_pkt_len = '0;
    logic [15:0] cfg_pkt_cnt = '0;
    logic [15:0] cfg_gap = '0;
    logic        tvalid, tlast, tready, busy, done;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
`ifdef AXIS_PKTGEN_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_pktgen_master dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .start         (start),
        .cfg_seed      (cfg_seed),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_pkt_cnt   (cfg_pkt_cnt),
        .cfg_gap       (cfg_gap),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready),
        .busy          (busy),
        .done          (done)
`ifdef AXIS_PKTGEN_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    typedef struct {
        logic [31:0] seed;
        int          len;
        int          cnt;
        int          gap;
        int          mode;
        bit          poke;
        int          exp_beats;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          beats = 0;
        int          gapc = 0;
        int          stalls = 0;
        int          vcount = 0;
        bit          in_gap = 0;
        bit          fin = 0;
        bit          pstall = 0;
        bit          el;
        logic [31:0] pd = '0;
        logic [31:0] expd;
        logic        pl = 1'b0;
        cfg_seed    = v.seed;
        cfg_pkt_len = 16'(v.len);
        cfg_pkt_cnt = 16'(v.cnt);
        cfg_gap     = 16'(v.gap);
        tready      = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (v.len == 0 || v.cnt == 0) begin
            chk("zero_tvalid", 64'(tvalid), 64'd0);
            chk("zero_done", 64'(done), 64'd1);
            @(posedge clk);
            #1;
            chk("zero_done_clr", 64'(done), 64'd0);
            chk("zero_busy_clr", 64'(busy), 64'd0);
            chk("zero_tvalid2", 64'(tvalid), 64'd0);
            return;
        end
        chk("start_tvalid", 64'(tvalid), 64'd1);
        chk("start_tdata", 64'(tdata), 64'(v.seed));
        for (int c = 0; c < 200 && !fin; c++) begin
            if (pstall) begin
                chk("stall_tdata", 64'(tdata), 64'(pd));
                chk("stall_tlast", 64'(tlast), 64'(pl));
            end
            if (v.poke && c == 2) begin
                start    = 1'b1;
                cfg_seed = 32'hDEAD0000;
            end else begin
                start = 1'b0;
            end
            case (v.mode)
                0: tready = 1'b1;
                1: tready = c[0];
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (in_gap) begin
                if (tvalid) begin
                    chk("gap_len", 64'(gapc), 64'(v.gap));
                    in_gap = 0;
                end else begin
                    gapc++;
                end
            end
            if (tvalid && tready) begin
                expd = v.seed + 32'(beats);
                el   = ((beats % v.len) == v.len - 1);
                chk("tdata", 64'(tdata), 64'(expd));
                chk("tlast", 64'(tlast), 64'(el));
                beats++;
                if (beats == v.exp_beats) fin = 1;
                else if (el) begin
                    in_gap = 1;
                    gapc   = 0;
                end
            end
            pstall = tvalid && !tready;
            if (pstall) stalls++;
            pd = tdata;
            pl = tlast;
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        tready = 1'b1;
        if (!fin) begin
            chk("timeout", 64'd0, 64'd1);
        end else begin
            chk("done_pulse", 64'(done), 64'd1);
            chk("done_tvalid", 64'(tvalid), 64'd0);
            chk("done_busy", 64'(busy), 64'd1);
            @(posedge clk);
            #1;
            chk("done_clr", 64'(done), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end
        chk("beat_total", 64'(beats), 64'(v.exp_beats));
`ifdef AXIS_PKTGEN_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
        if (v.poke) begin
            for (int k = 0; k < 5; k++) begin
                if (tvalid) vcount++;
                @(posedge clk);
                #1;
            end
            chk("poke_no_rerun", 64'(vcount), 64'd0);
        end
    endtask

    initial begin
        vt[0] = '{32'h10,       4, 1, 0, 0, 1, 4};
        vt[1] = '{32'h0,        3, 2, 2, 0, 0, 6};
        vt[2] = '{32'h100,      5, 1, 0, 2, 0, 5};
        vt[3] = '{32'hFFFFFFFE, 4, 1, 0, 0, 0, 4};
        vt[4] = '{32'h20,       2, 3, 0, 1, 0, 6};
        vt[5] = '{32'h30,       0, 3, 0, 0, 0, 0};
        vt[6] = '{32'h40,       3, 0, 1, 0, 0, 0};
        vt[7] = '{32'h50,       2, 2, 1, 1, 0, 4};

        tready = 1'b1;
        #2;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_tstrb", 64'(tstrb), 64'hF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        cfg_seed    = 32'h77;
        cfg_pkt_len = 16'd2;
        cfg_pkt_cnt = 16'd1;
        cfg_gap     = 16'd0;
        tready      = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 tready = 1'b0;
        chk("pre_rst_tdata", 64'(tdata), 64'h78);
        @(posedge clk);
        #1;
        chk("pre_rst_tlast", 64'(tlast), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
        chk("mid_rst_tlast", 64'(tlast), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_tdata", 64'(tdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(tvalid), 64'd0);
        run_vec('{32'h200, 3, 1, 0, 0, 0, 3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
